// File: rtl/text_write_ctrl.sv
// Write-port sequencer for the 4x32 VGA text RAM: UART byte FIFO, control decode,
// cursor tracking and clear sweep. Define TEXT_WRITE_CTRL_BS_EN to decode 0x08 as backspace.
module text_write_ctrl #(
  parameter int COL_W      = 5,
  parameter int ROW_W      = 2,
  parameter int HOME_COL   = 24,
  parameter int HOME_ROW   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  input  logic             clr_req,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [7:0]       wr_data,
  output logic [ROW_W-1:0] cur_row,
  output logic [COL_W-1:0] cur_col,
  output logic             busy,
  output logic             overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = ROW_W + COL_W;
  localparam logic [COL_W-1:0] HOME_C    = COL_W'(HOME_COL);
  localparam logic [COL_W-1:0] LAST_C    = COL_W'(HOME_COL - 1);
  localparam logic [ROW_W-1:0] HOME_R    = ROW_W'(HOME_ROW);
  localparam logic [CNT_W-1:0] LAST_CELL = '1;
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef TEXT_WRITE_CTRL_BS_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic [CNT_W-1:0] clr_cnt_q;
  logic [ROW_W-1:0] cur_row_q, wr_row_q;
  logic [COL_W-1:0] cur_col_q, wr_col_q;
  logic [7:0]       wr_data_q;
  logic             wr_en_q, busy_q, overflow_q;

  logic             fifo_full, fifo_empty, push, pop;
  logic [7:0]       head;
  logic             dec_wr;
  logic [COL_W-1:0] dec_col, nxt_col;
  logic [ROW_W-1:0] nxt_row;
  logic [7:0]       dec_data;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign push       = rx_valid && !fifo_full;
  assign pop        = (state_q == IDLE) && !clr_req && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q];

  // NOTE: every signal gets a default before any branch, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    dec_wr   = 1'b0;
    dec_col  = cur_col_q;
    dec_data = head;
    nxt_row  = cur_row_q;
    nxt_col  = cur_col_q;
    if (head == 8'h0D || head == 8'h0A) begin
      nxt_row = cur_row_q + ROW_W'(1);
      nxt_col = HOME_C;
    end else if (BS_EN && head == 8'h08) begin
      if (cur_col_q != HOME_C) begin
        // NOTE: blocking assignments inside always_comb, so dec_col sees the updated nxt_col.
        nxt_col  = cur_col_q - COL_W'(1);
        dec_wr   = 1'b1;
        dec_col  = nxt_col;
        dec_data = 8'h20;
      end
    end else if (head >= 8'h20 && head != 8'h7F) begin
      dec_wr = 1'b1;
      if (cur_col_q == LAST_C) begin
        nxt_col = HOME_C;
        nxt_row = cur_row_q + ROW_W'(1);
      end else begin
        nxt_col = cur_col_q + COL_W'(1);
      end
    end
  end

  // NOTE: the FIFO array has no reset; an entry is only read after it is written,
  // so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      clr_cnt_q  <= '0;
      cur_row_q  <= HOME_R;
      cur_col_q  <= HOME_C;
      wr_en_q    <= 1'b0;
      wr_row_q   <= '0;
      wr_col_q   <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: count_q <= count_q;
      endcase

      // A byte dropped in the same cycle as a clear request still flags.
      if (rx_valid && fifo_full)
        overflow_q <= 1'b1;
      else if (state_q == IDLE && clr_req)
        overflow_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (clr_req) begin
            // Cell 0 is issued at this edge so the sweep is visible the next cycle.
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            wr_en_q   <= 1'b1;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= 8'h20;
            clr_cnt_q <= CNT_W'(1);
          end else if (!fifo_empty) begin
            wr_en_q   <= dec_wr;
            cur_row_q <= nxt_row;
            cur_col_q <= nxt_col;
            if (dec_wr) begin
              wr_row_q  <= cur_row_q;
              wr_col_q  <= dec_col;
              wr_data_q <= dec_data;
            end
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        CLEAR: begin
          wr_en_q   <= 1'b1;
          wr_row_q  <= clr_cnt_q[CNT_W-1:COL_W];
          wr_col_q  <= clr_cnt_q[COL_W-1:0];
          wr_data_q <= 8'h20;
          clr_cnt_q <= clr_cnt_q + CNT_W'(1);
          if (clr_cnt_q == LAST_CELL) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            cur_row_q <= HOME_R;
            cur_col_q <= HOME_C;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_row   = wr_row_q;
  assign wr_col   = wr_col_q;
  assign wr_data  = wr_data_q;
  assign cur_row  = cur_row_q;
  assign cur_col  = cur_col_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_text_write_ctrl.sv
// Self-checking bench for text_write_ctrl: decode vector table, hand-written wrap/clear
// sequences, and random traffic against a queue-based reference model.
module tb_text_write_ctrl;

  localparam int COLS     = 32;
  localparam int ROWS     = 4;
  localparam int HOME_COL = 24;
  localparam int HOME_ROW = 1;
  localparam int DEPTH    = 4;
  localparam int CELLS    = ROWS * COLS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_req = 1'b0;
  logic       wr_en;
  logic [1:0] wr_row, cur_row;
  logic [4:0] wr_col, cur_col;
  logic [7:0] wr_data;
  logic       busy, overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  text_write_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .clr_req  (clr_req),
    .wr_en    (wr_en),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .cur_row  (cur_row),
    .cur_col  (cur_col),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1 ns after each rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c);
    rx_valid = v;
    rx_data  = d;
    clr_req  = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    cycle();
    reset = 1'b0;
  endtask

  // Reference model: byte queue, cursor as integers, sweep index.
  logic [7:0] m_q[$];
  bit         m_clear;
  int         m_sweep, m_row, m_col;
  bit         m_ovf;
  bit         e_wr;
  int         e_row, e_col;
  logic [7:0] e_data;

  function automatic void model_decode(input logic [7:0] b);
    if (b == 8'h0D || b == 8'h0A) begin
      e_wr  = 1'b0;
      m_col = HOME_COL;
      m_row = (m_row + 1) % ROWS;
    end
`ifdef TEXT_WRITE_CTRL_BS_EN
    else if (b == 8'h08) begin
      if (m_col != HOME_COL) begin
        m_col  = (m_col + COLS - 1) % COLS;
        e_wr   = 1'b1;
        e_row  = m_row;
        e_col  = m_col;
        e_data = 8'h20;
      end else begin
        e_wr = 1'b0;
      end
    end
`endif
    else if (b < 8'h20 || b == 8'h7F) begin
      e_wr = 1'b0;
    end else begin
      e_wr   = 1'b1;
      e_row  = m_row;
      e_col  = m_col;
      e_data = b;
      if (m_col == (HOME_COL + COLS - 1) % COLS) begin
        m_col = HOME_COL;
        m_row = (m_row + 1) % ROWS;
      end else begin
        m_col = (m_col + 1) % COLS;
      end
    end
  endfunction

  function automatic void model_step(input bit rst, input bit v, input logic [7:0] d, input bit c);
    bit full;
    if (rst) begin
      m_q.delete();
      m_clear = 1'b0;
      m_sweep = 0;
      m_row   = HOME_ROW;
      m_col   = HOME_COL;
      m_ovf   = 1'b0;
      e_wr    = 1'b0;
      return;
    end
    full = (m_q.size() == DEPTH);
    if (m_clear) begin
      e_wr   = 1'b1;
      e_row  = m_sweep / COLS;
      e_col  = m_sweep % COLS;
      e_data = 8'h20;
      if (m_sweep == CELLS - 1) begin
        m_clear = 1'b0;
        m_row   = HOME_ROW;
        m_col   = HOME_COL;
      end
      m_sweep++;
    end else if (c) begin
      m_clear = 1'b1;
      m_ovf   = 1'b0;
      e_wr    = 1'b1;
      e_row   = 0;
      e_col   = 0;
      e_data  = 8'h20;
      m_sweep = 1;
    end else if (m_q.size() > 0) begin
      model_decode(m_q.pop_front());
    end else begin
      e_wr = 1'b0;
    end
    if (v) begin
      if (full) m_ovf = 1'b1;
      else      m_q.push_back(d);
    end
  endfunction

  task automatic compare_model(input int cyc);
    check($sformatf("rnd%0d wr_en", cyc), wr_en, e_wr);
    if (e_wr) begin
      check($sformatf("rnd%0d wr_row", cyc), wr_row, e_row);
      check($sformatf("rnd%0d wr_col", cyc), wr_col, e_col);
      check($sformatf("rnd%0d wr_data", cyc), wr_data, e_data);
    end
    check($sformatf("rnd%0d cur_row", cyc), cur_row, m_row);
    check($sformatf("rnd%0d cur_col", cyc), cur_col, m_col);
    check($sformatf("rnd%0d busy", cyc), busy, m_clear);
    check($sformatf("rnd%0d overflow", cyc), overflow, m_ovf);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         wr;
    int         row;
    int         col;
    logic [7:0] wdata;
    int         crow;
    int         ccol;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] abc[6];

  initial begin
    // Applied in order from reset; each byte is sent alone.
    vecs[0]  = '{8'h41, 1'b1, 1, 24, 8'h41, 1, 25};
    vecs[1]  = '{8'h42, 1'b1, 1, 25, 8'h42, 1, 26};
`ifdef TEXT_WRITE_CTRL_BS_EN
    vecs[2]  = '{8'h08, 1'b1, 1, 25, 8'h20, 1, 25};
    vecs[3]  = '{8'h01, 1'b0, 0, 0, 8'h00, 1, 25};
    vecs[4]  = '{8'h7F, 1'b0, 0, 0, 8'h00, 1, 25};
    vecs[5]  = '{8'h7E, 1'b1, 1, 25, 8'h7E, 1, 26};
`else
    vecs[2]  = '{8'h08, 1'b0, 0, 0, 8'h00, 1, 26};
    vecs[3]  = '{8'h01, 1'b0, 0, 0, 8'h00, 1, 26};
    vecs[4]  = '{8'h7F, 1'b0, 0, 0, 8'h00, 1, 26};
    vecs[5]  = '{8'h7E, 1'b1, 1, 26, 8'h7E, 1, 27};
`endif
    vecs[6]  = '{8'h0D, 1'b0, 0, 0, 8'h00, 2, 24};
    vecs[7]  = '{8'h20, 1'b1, 2, 24, 8'h20, 2, 25};
    vecs[8]  = '{8'h0A, 1'b0, 0, 0, 8'h00, 3, 24};
    vecs[9]  = '{8'h0A, 1'b0, 0, 0, 8'h00, 0, 24};
    vecs[10] = '{8'h08, 1'b0, 0, 0, 8'h00, 0, 24};
    vecs[11] = '{8'h1F, 1'b0, 0, 0, 8'h00, 0, 24};
    vecs[12] = '{8'h80, 1'b1, 0, 24, 8'h80, 0, 25};
    abc = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    // Reset state.
    do_reset();
    check("rst wr_en", wr_en, 0);
    check("rst wr_row", wr_row, 0);
    check("rst wr_col", wr_col, 0);
    check("rst wr_data", wr_data, 0);
    check("rst cur_row", cur_row, HOME_ROW);
    check("rst cur_col", cur_col, HOME_COL);
    check("rst busy", busy, 0);
    check("rst overflow", overflow, 0);

    // Decode table.
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].data, 1'b0);
      cycle();
      drive(1'b0, 8'h00, 1'b0);
      check($sformatf("vec%0d early wr_en", i), wr_en, 0);
      cycle();
      check($sformatf("vec%0d wr_en", i), wr_en, vecs[i].wr);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d wr_row", i), wr_row, vecs[i].row);
        check($sformatf("vec%0d wr_col", i), wr_col, vecs[i].col);
        check($sformatf("vec%0d wr_data", i), wr_data, vecs[i].wdata);
      end
      check($sformatf("vec%0d cur_row", i), cur_row, vecs[i].crow);
      check($sformatf("vec%0d cur_col", i), cur_col, vecs[i].ccol);
      cycle();
      check($sformatf("vec%0d trailing wr_en", i), wr_en, 0);
    end

    // Line wrap: 32 bytes back-to-back on row 1, then again on row 3.
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      int row;
      row = (pass == 0) ? 1 : 3;
      for (int i = 0; i < 34; i++) begin
        if (i >= 2) begin
          check($sformatf("wrap%0d.%0d wr_en", pass, i - 2), wr_en, 1);
          check($sformatf("wrap%0d.%0d wr_row", pass, i - 2), wr_row, row);
          check($sformatf("wrap%0d.%0d wr_col", pass, i - 2), wr_col,
                (i - 2 < 8) ? (24 + i - 2) : (i - 2 - 8));
          check($sformatf("wrap%0d.%0d wr_data", pass, i - 2), wr_data, 8'(8'h30 + i - 2));
        end
        if (i < 32) drive(1'b1, 8'(8'h30 + i), 1'b0);
        else        drive(1'b0, 8'h00, 1'b0);
        cycle();
      end
      check($sformatf("wrap%0d end cur_row", pass), cur_row, (pass == 0) ? 2 : 0);
      check($sformatf("wrap%0d end cur_col", pass), cur_col, 24);
      if (pass == 0) begin
        drive(1'b1, 8'h0A, 1'b0);
        cycle();
        drive(1'b0, 8'h00, 1'b0);
        cycle();
        check("wrap lf cur_row", cur_row, 3);
        check("wrap lf cur_col", cur_col, 24);
      end
    end

    // Clear sweep with "ABCDEF" arriving during it.
    begin
      int good, busy_bad;
      good = 0;
      busy_bad = 0;
      do_reset();
      drive(1'b0, 8'h00, 1'b1);
      cycle();
      for (int i = 0; i < CELLS; i++) begin
        if (wr_en === 1'b1 && wr_data === 8'h20 &&
            wr_row === 2'(i / COLS) && wr_col === 5'(i % COLS))
          good++;
        if (busy !== ((i < CELLS - 1) ? 1'b1 : 1'b0)) busy_bad++;
        if (i == 7) check("clear overflow", overflow, 1);
        if (i < 6)       drive(1'b1, abc[i], 1'b0);
        else if (i == 10) drive(1'b0, 8'h00, 1'b1);
        else              drive(1'b0, 8'h00, 1'b0);
        cycle();
      end
      check("clear writes", good, CELLS);
      check("clear busy pattern", busy_bad, 0);
      for (int j = 0; j < 4; j++) begin
        check($sformatf("post-clear%0d wr_en", j), wr_en, 1);
        check($sformatf("post-clear%0d wr_row", j), wr_row, 1);
        check($sformatf("post-clear%0d wr_col", j), wr_col, 24 + j);
        check($sformatf("post-clear%0d wr_data", j), wr_data, abc[j]);
        cycle();
      end
      check("post-clear idle wr_en", wr_en, 0);
      check("post-clear cur_row", cur_row, 1);
      check("post-clear cur_col", cur_col, 28);
      check("post-clear overflow", overflow, 1);
      check("post-clear busy", busy, 0);
    end

    // Reset in the middle of a sweep aborts it.
    begin
      int stray;
      stray = 0;
      drive(1'b0, 8'h00, 1'b1);
      cycle();
      drive(1'b0, 8'h00, 1'b0);
      repeat (10) cycle();
      check("abort busy before", busy, 1);
      do_reset();
      for (int i = 0; i < 5; i++) begin
        if (wr_en !== 1'b0 || busy !== 1'b0) stray++;
        cycle();
      end
      check("abort stray writes", stray, 0);
      check("abort cur_row", cur_row, HOME_ROW);
      check("abort cur_col", cur_col, HOME_COL);
    end

    // Random traffic against the reference model.
    do_reset();
    model_step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      bit r, v, c;
      logic [7:0] d;
      compare_model(i);
      r = ($urandom_range(0, 999) == 0);
      v = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 199) == 0);
      case ($urandom_range(0, 5))
        0:       d = 8'h0D;
        1:       d = 8'h0A;
        2:       d = 8'h08;
        3:       d = 8'($urandom_range(0, 255));
        default: d = 8'($urandom_range(8'h20, 8'h7E));
      endcase
      reset = r;
      drive(v, d, c);
      model_step(r, v, d, c);
      cycle();
    end
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
